// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: operands are latched on start and summed LSB-first,
// DIGIT bits per cycle, through a full-adder slice with a registered carry.
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic [1:0]       state_o
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_adder: illegal WIDTH/DIGIT combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT:0]   slice;
    logic             msb_cin;

    // One digit of the ripple: {carry_out, digit} for the lowest DIGIT bits still in flight.
    assign slice   = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]} + (DIGIT+1)'(c_q);
    // On the final digit the low operand bits are the original MSBs, so this recovers the MSB carry-in.
    assign msb_cin = slice[DIGIT-1] ^ opa_q[DIGIT-1] ^ opb_q[DIGIT-1];

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    c_d     = sub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                opa_d  = opa_q >> DIGIT;
                opb_d  = opb_q >> DIGIT;
                c_d    = slice[DIGIT];
                psum_d = (psum_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    sum_d   = psum_d;
                    carry_d = slice[DIGIT];
                    ovf_d   = slice[DIGIT] ^ msb_cin;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign sum      = sum_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: five instances (DIGIT = 1,2,4,8,16) sharing operands and reset,
// each with its own start, checked against directed vectors and an arithmetic model.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        start_v [5];
    logic        busy_w  [5];
    logic        done_w  [5];
    logic        carry_w [5];
    logic        ovf_w   [5];
    logic [15:0] sum_w   [5];
    logic [1:0]  state_w [5];

    int checks = 0;
    int errors = 0;

    logic [17:0] exp_q [$];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 5; g++) begin : g_dut
            serial_adder #(.WIDTH(16), .DIGIT(1 << g)) u_dut (
                .clk      (clk),
                .reset    (reset),
                .start    (start_v[g]),
                .sub      (sub),
                .a        (a),
                .b        (b),
                .busy     (busy_w[g]),
                .done     (done_w[g]),
                .sum      (sum_w[g]),
                .carry    (carry_w[g]),
                .overflow (ovf_w[g]),
                .state_o  (state_w[g])
            );
        end
    endgenerate

    typedef struct {
        logic        s;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] e_sum;
        logic        e_c;
        logic        e_v;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: {overflow, carry, sum} from plain 17-bit arithmetic and the sign rule.
    function automatic logic [17:0] model(input logic s, input logic [15:0] x, input logic [15:0] y);
        logic [16:0] r;
        logic        v;
        if (s) r = {1'b0, x} + {1'b0, ~y} + 17'd1;
        else   r = {1'b0, x} + {1'b0, y};
        if (s) v = (x[15] != y[15]) && (r[15] != x[15]);
        else   v = (x[15] == y[15]) && (r[15] != x[15]);
        return {v, r[16], r[15:0]};
    endfunction

    task automatic run_op(input int k, input logic s, input logic [15:0] x, input logic [15:0] y,
                          output int lat, output int bcnt);
        @(negedge clk);
        a = x; b = y; sub = s; start_v[k] = 1'b1;
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        lat = 0;
        bcnt = 0;
        while (done_w[k] !== 1'b1 && lat < 40) begin
            if (busy_w[k] === 1'b1) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic chk_res(input int k, input logic [15:0] e_sum, input logic e_c, input logic e_v);
        chk($sformatf("sum[d%0d]", 1 << k), 32'(sum_w[k]), 32'(e_sum));
        chk($sformatf("carry[d%0d]", 1 << k), 32'(carry_w[k]), 32'(e_c));
        chk($sformatf("overflow[d%0d]", 1 << k), 32'(ovf_w[k]), 32'(e_v));
    endtask

    initial begin
        int lat;
        int lat2;
        int bcnt;
        int pulses;
        logic [17:0] e;
        logic        rs;
        logic [15:0] rx;
        logic [15:0] ry;

        tbl[0] = '{1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 16'h0007, 16'h0007, 16'h0000, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0};

        // Reset state
        for (int k = 0; k < 5; k++) start_v[k] = 1'b0;
        reset = 1'b1; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("reset busy", 32'(busy_w[k]), 32'd0);
            chk("reset done", 32'(done_w[k]), 32'd0);
            chk_res(k, 16'h0000, 1'b0, 1'b0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors on every DIGIT configuration
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 5; k++) begin
                run_op(k, tbl[i].s, tbl[i].x, tbl[i].y, lat, bcnt);
                chk($sformatf("latency v%0d", i), 32'(lat), 32'(16 >> k));
                chk($sformatf("busy cycles v%0d", i), 32'(bcnt), 32'(16 >> k));
                chk_res(k, tbl[i].e_sum, tbl[i].e_c, tbl[i].e_v);
                @(posedge clk); #1;
                chk("done pulse width", 32'(done_w[k]), 32'd0);
            end
        end

        // Start and operand changes during RUN are ignored
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        lat = 0;
        while (done_w[0] !== 1'b1 && lat < 40) begin
            if (lat == 3) begin
                a = 16'hAAAA; b = 16'h5555; sub = 1'b1; start_v[0] = 1'b1;
            end
            if (lat == 6) start_v[0] = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        start_v[0] = 1'b0;
        chk("latency start-in-run", 32'(lat), 32'd16);
        chk_res(0, 16'h3333, 1'b0, 1'b0);

        // Reset in the 5th RUN cycle aborts with no later done pulse
        @(negedge clk);
        a = 16'h00FF; b = 16'h0F0F; sub = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort busy", 32'(busy_w[0]), 32'd0);
        chk("abort done", 32'(done_w[0]), 32'd0);
        chk_res(0, 16'h0000, 1'b0, 1'b0);
        pulses = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done_w[0] !== 1'b0) pulses++;
        end
        chk("done after abort", 32'(pulses), 32'd0);
        run_op(0, 1'b0, 16'h0003, 16'h0004, lat, bcnt);
        chk("latency after abort", 32'(lat), 32'd16);
        chk_res(0, 16'h0007, 1'b0, 1'b0);

        // DIGIT=4 back-to-back with start held through DONE
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; sub = 1'b0; start_v[2] = 1'b1;
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'hFFFF;
        lat = 0;
        while (done_w[2] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b first latency", 32'(lat), 32'd4);
        chk_res(2, 16'h5555, 1'b0, 1'b0);
        @(posedge clk); #1;
        start_v[2] = 1'b0;
        lat2 = 1;
        chk("b2b accepted in done", 32'(busy_w[2]), 32'd1);
        while (done_w[2] !== 1'b1 && lat2 < 40) begin
            @(posedge clk); #1;
            lat2++;
        end
        chk("b2b second spacing", 32'(lat2), 32'd5);
        chk_res(2, 16'hFFFE, 1'b1, 1'b0);

        // Random sweep against the arithmetic model
        for (int k = 0; k < 5; k++) begin
            for (int n = 0; n < 1000; n++) begin
                rx = 16'($urandom_range(0, 65535));
                ry = 16'($urandom_range(0, 65535));
                rs = 1'($urandom_range(0, 1));
                exp_q.push_back(model(rs, rx, ry));
                run_op(k, rs, rx, ry, lat, bcnt);
                chk("rand latency", 32'(lat), 32'(16 >> k));
                e = exp_q.pop_front();
                chk_res(k, e[15:0], e[16], e[17]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
